cache_fill_fsm: RTL
===================

Name: cache_fill_fsm

Overview:
- Miss-handling engine between the CPU's instruction/data caches and the 4-cycle pipelined main memory.
- On a cache miss it reads the whole block from memory, one word request per cycle.
- Each returned word is written into the cache data array; the tag is written with the last word.
- fsm_busy stalls the CPU pipeline for the whole fill.

Parameters:
- WORDS_PER_BLOCK, 8, 16-bit words per cache block; power of 2, at least 2.
- IDX_W, 3, log2(WORDS_PER_BLOCK); width of the word-select output.
- TAG_W, 12, tag width; equals 16 - (IDX_W+1) at defaults.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- miss_detected  in  1  cache miss in the current cycle, level.
- miss_address  in  16  byte address of the missing access.
- fsm_busy  out  1  fill in progress; stall the pipeline.
- mem_read  out  1  memory read request, one word per cycle.
- memory_address  out  16  byte address of the request.
- memory_data_valid  in  1  memory_data holds a returned word.
- memory_data  in  16  returned word.
- write_data_array  out  1  write cache_wdata at data_word_sel.
- data_word_sel  out  IDX_W  word offset within the block being written.
- cache_wdata  out  16  word to write; combinational copy of memory_data.
- write_tag_array  out  1  write tag_out into the tag array.
- tag_out  out  TAG_W  tag of the filled block: base[15:16-TAG_W].

Behaviour:
- Reset (rst_n low, asynchronous) sets:
  - state to IDLE;
  - issue_cnt and recv_cnt to 0;
  - base to 0x0000.
- With the state IDLE, every output is 0:
  - fsm_busy, mem_read, write_data_array and write_tag_array are low;
  - memory_address, data_word_sel and tag_out are 0;
  - cache_wdata follows memory_data but is qualified by write_data_array.
- States: IDLE, FILL.
  - IDLE -> FILL when miss_detected=1 at the clock edge. The same edge latches base = miss_address with bits [IDX_W:0] cleared.
  - FILL -> IDLE at the edge where memory_data_valid=1 and recv_cnt=WORDS_PER_BLOCK-1.
- fsm_busy is Moore: 1 exactly while the state is FILL. It is never high in IDLE.
- Request issue:
  - In FILL with issue_cnt < WORDS_PER_BLOCK: mem_read=1 and memory_address = base + 2*issue_cnt.
  - issue_cnt increments every FILL cycle until it reaches WORDS_PER_BLOCK. After that mem_read=0 and memory_address holds its last value.
- Data return, in FILL when memory_data_valid=1:
  - write_data_array=1 and data_word_sel=recv_cnt, combinationally in the same cycle;
  - recv_cnt increments at the edge.
  - Valid cycles need not be contiguous; the FSM stays in FILL until all WORDS_PER_BLOCK words have arrived.
- Tag write: write_tag_array=1 only in the cycle that writes the last word. tag_out is driven from base in FILL.
- Latency at the defaults with the 4-cycle memory:
  - miss sampled at edge E0;
  - requests in cycles 1..8;
  - data in cycles 5..12;
  - fsm_busy high in cycles 1..12 (WORDS_PER_BLOCK + 4 cycles);
  - fsm_busy low in cycle 13.
- Counters clear on entry to FILL. The address arithmetic is 16-bit, but a block never crosses a block boundary, so it never wraps.
- miss_detected while in FILL is ignored. miss_address changes during FILL are ignored, because base is latched.
- miss_detected asserted in the same cycle as the final valid: ignored. A new fill starts only from IDLE, one cycle later, if miss_detected is still asserted.
- memory_data_valid in IDLE is ignored: no writes, no state change.
- memory_data_valid after all WORDS_PER_BLOCK words, while still in FILL, cannot occur. Once recv_cnt wraps, the FSM has already left FILL.
- Reset mid-fill: immediate return to IDLE with all outputs 0. No tag write for the partial block. The memory shares rst_n, so no stale returns follow.

Test Plan:
- Reset: rst_n low mid-simulation, asynchronous to clk -> every output 0 before the next edge, and the state is IDLE.
- Basic fill: miss_address=0x1234, memory returns 0xA000+i at 4-cycle latency:
  - memory_address runs 0x1230,0x1232,...,0x123E in cycles 1..8;
  - write_data_array in cycles 5..12 with data_word_sel 0..7 and cache_wdata 0xA000..0xA007;
  - write_tag_array only in cycle 12 with tag_out=0x123;
  - fsm_busy high in cycles 1..12, low in cycle 13.
- Gapped returns: valid deasserted for 3 cycles after the 4th word -> fsm_busy extends by 3 cycles, all 8 writes still occur, and the tag is written with word 7.
- Ignored inputs: miss_detected held high with miss_address changed to 0xFFFF during the fill, plus a spurious memory_data_valid in IDLE -> no writes while IDLE, no address change, tag_out stays 0x123.
- Back-to-back: miss held high through the end of a fill -> one IDLE cycle, then a new fill with base recomputed from the current miss_address.
- Abort: rst_n pulsed low after the 5th word of a fill -> outputs 0 at once and no write_tag_array. A fresh miss at 0x0000 then completes normally: addresses 0x0000..0x000E and tag_out=0x000.

Source files
------------

// File: rtl/cache_fill_fsm.sv
// Cache miss fill engine: on a miss, streams WORDS_PER_BLOCK word reads from a pipelined
// memory, writes each returned word into the data array and the tag with the last word.
module cache_fill_fsm #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int IDX_W           = 3,
  parameter int TAG_W           = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             miss_detected,
  input  logic [15:0]      miss_address,
  output logic             fsm_busy,
  output logic             mem_read,
  output logic [15:0]      memory_address,
  input  logic             memory_data_valid,
  input  logic [15:0]      memory_data,
  output logic             write_data_array,
  output logic [IDX_W-1:0] data_word_sel,
  output logic [15:0]      cache_wdata,
  output logic             write_tag_array,
  output logic [TAG_W-1:0] tag_out
);

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  localparam logic [IDX_W:0]   LP_WPB        = (IDX_W+1)'(WORDS_PER_BLOCK);
  localparam logic [IDX_W:0]   LP_LAST_ISSUE = (IDX_W+1)'(WORDS_PER_BLOCK-1);
  localparam logic [IDX_W-1:0] LP_LAST_RECV  = IDX_W'(WORDS_PER_BLOCK-1);
  // Byte-offset bits within a block: IDX_W word-select bits plus the byte-in-word bit.
  localparam logic [15:0]      LP_OFS_MASK   = 16'((1 << (IDX_W+1)) - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W:0]   r_issue_cnt;
  logic [IDX_W-1:0] r_recv_cnt;
  logic [15:0]      r_base;
  logic             w_issue_done;
  logic [IDX_W:0]   w_issue_idx;
  logic [15:0]      w_issue_ofs;

  assign w_issue_done = (r_issue_cnt == LP_WPB);
  // Once every request is out, the address parks on the last word of the block.
  assign w_issue_idx  = w_issue_done ? LP_LAST_ISSUE : r_issue_cnt;
  assign w_issue_ofs  = 16'(w_issue_idx) << 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
      r_base      <= '0;
    end else if (r_state == IDLE) begin
      if (miss_detected) begin
        r_base      <= miss_address & ~LP_OFS_MASK;
        r_issue_cnt <= '0;
        r_recv_cnt  <= '0;
      end
    end else begin
      if (!w_issue_done) begin
        r_issue_cnt <= r_issue_cnt + 1'b1;
      end
      if (memory_data_valid) begin
        r_recv_cnt <= r_recv_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    fsm_busy         = 1'b0;
    mem_read         = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    data_word_sel    = '0;
    cache_wdata      = '0;
    write_tag_array  = 1'b0;
    tag_out          = '0;
    case (r_state)
      IDLE: begin
        if (miss_detected) begin
          w_state_nxt = FILL;
        end
      end
      FILL: begin
        fsm_busy       = 1'b1;
        mem_read       = !w_issue_done;
        memory_address = r_base + w_issue_ofs;
        tag_out        = r_base[15 -: TAG_W];
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          data_word_sel    = r_recv_cnt;
          cache_wdata      = memory_data;
          // The last returned word closes the fill and carries the tag write.
          if (r_recv_cnt == LP_LAST_RECV) begin
            write_tag_array = 1'b1;
            w_state_nxt     = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule
